// File: rtl/rns_fwd_conv_10d_if.sv
// rtl/rns_fwd_conv_10d_if.sv - handshake and digit bus of the 10-digit RNS forward converter
interface rns_fwd_conv_10d_if #(
  parameter int IN_WIDTH  = 64,
  parameter int DIG_WIDTH = 18
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [DIG_WIDTH-1:0] dig_out_1_;
  logic [DIG_WIDTH-1:0] dig_out_2_;
  logic [DIG_WIDTH-1:0] dig_out_3_;
  logic [DIG_WIDTH-1:0] dig_out_4_;
  logic [DIG_WIDTH-1:0] dig_out_5_;
  logic [DIG_WIDTH-1:0] dig_out_6_;
  logic [DIG_WIDTH-1:0] dig_out_7_;
  logic [DIG_WIDTH-1:0] dig_out_8_;
  logic [DIG_WIDTH-1:0] dig_out_9_;
  logic [DIG_WIDTH-1:0] dig_out_10_;
  logic                 busy;

  // Producer/consumer side: supplies the value and accepts the residues.
  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, busy,
    input  dig_out_1_, dig_out_2_, dig_out_3_, dig_out_4_, dig_out_5_,
    input  dig_out_6_, dig_out_7_, dig_out_8_, dig_out_9_, dig_out_10_
  );

  // Converter side.
  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, busy,
    output dig_out_1_, dig_out_2_, dig_out_3_, dig_out_4_, dig_out_5_,
    output dig_out_6_, dig_out_7_, dig_out_8_, dig_out_9_, dig_out_10_
  );
endinterface

// File: rtl/rns_fwd_conv_10d.sv
// rtl/rns_fwd_conv_10d.sv - bit-serial binary to 10-digit residue forward converter
module rns_fwd_conv_10d #(
  parameter int          IN_WIDTH  = 64,
  parameter int          DIG_WIDTH = 18,
  parameter int unsigned M1        = 65536,
  parameter int unsigned M2        = 78125,
  parameter int unsigned M3        = 117649,
  parameter int unsigned M4        = 177147,
  parameter int unsigned M5        = 262027,
  parameter int unsigned M6        = 262049,
  parameter int unsigned M7        = 262051,
  parameter int unsigned M8        = 262069,
  parameter int unsigned M9        = 262079,
  parameter int unsigned M10       = 262103
) (
  input logic                clk,
  input logic                rst_n,
  rns_fwd_conv_10d_if.slave  bus
);

  localparam int NDIG = 10;
  localparam int CW   = $clog2(IN_WIDTH);
  localparam int TW   = DIG_WIDTH + 1;

  // Moduli widened by one bit so they compare directly against 2*r + bit.
  localparam logic [DIG_WIDTH:0] MOD [NDIG] = '{
    TW'(M1), TW'(M2), TW'(M3), TW'(M4), TW'(M5),
    TW'(M6), TW'(M7), TW'(M8), TW'(M9), TW'(M10)
  };

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  mag_q, mag_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DIG_WIDTH-1:0] r_q     [NDIG];
  logic [DIG_WIDTH-1:0] r_d     [NDIG];
  logic [DIG_WIDTH-1:0] shift_r [NDIG];
  logic [DIG_WIDTH-1:0] fix_r   [NDIG];
  logic [DIG_WIDTH:0]   t_w     [NDIG];
  logic                 accept;
  logic                 in_neg;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign in_neg = bus.in_signed && bus.in_data[IN_WIDTH-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one accept, IN_WIDTH shift steps, one sign fix, then hold for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)    state_d = SHIFT;
      SHIFT:   if (cnt_q == '0)     state_d = FIX;
      FIX:                          state_d = DONE;
      DONE:    if (bus.out_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q == SHIFT) || (state_q == FIX);
  end

  // Per-digit candidates: one MSB-first doubling step, and the negation for signed inputs.
  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      t_w[i]     = {r_q[i], mag_q[cnt_q]};
      shift_r[i] = (t_w[i] >= MOD[i]) ? DIG_WIDTH'(t_w[i] - MOD[i]) : t_w[i][DIG_WIDTH-1:0];
      fix_r[i]   = (neg_q && (r_q[i] != '0)) ? DIG_WIDTH'(MOD[i] - {1'b0, r_q[i]}) : r_q[i];
    end
  end

  // Datapath next values: capture magnitude/sign on accept, then step or fix residues.
  always_comb begin
    mag_d = mag_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    r_d   = r_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mag_d = in_neg ? (-bus.in_data) : bus.in_data;
          neg_d = in_neg;
          cnt_d = CW'(IN_WIDTH - 1);
          for (int i = 0; i < NDIG; i++) r_d[i] = '0;
        end
      end
      SHIFT: begin
        r_d   = shift_r;
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
      end
      FIX:     r_d = fix_r;
      default: ;
    endcase
  end

  // Datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      for (int i = 0; i < NDIG; i++) r_q[i] <= '0;
    end else begin
      mag_q <= mag_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
      r_q   <= r_d;
    end
  end

  assign bus.dig_out_1_  = r_q[0];
  assign bus.dig_out_2_  = r_q[1];
  assign bus.dig_out_3_  = r_q[2];
  assign bus.dig_out_4_  = r_q[3];
  assign bus.dig_out_5_  = r_q[4];
  assign bus.dig_out_6_  = r_q[5];
  assign bus.dig_out_7_  = r_q[6];
  assign bus.dig_out_8_  = r_q[7];
  assign bus.dig_out_9_  = r_q[8];
  assign bus.dig_out_10_ = r_q[9];

endmodule

// File: tb/tb_rns_fwd_conv_10d.sv
// tb/tb_rns_fwd_conv_10d.sv - directed self-checking bench for rns_fwd_conv_10d
module tb_rns_fwd_conv_10d;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  localparam longint unsigned MODS [10] = '{
    65536, 78125, 117649, 177147, 262027, 262049, 262051, 262069, 262079, 262103
  };

  rns_fwd_conv_10d_if #(.IN_WIDTH(64), .DIG_WIDTH(18)) bus ();

  rns_fwd_conv_10d dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] dig(input int i);
    case (i)
      0: return bus.dig_out_1_;
      1: return bus.dig_out_2_;
      2: return bus.dig_out_3_;
      3: return bus.dig_out_4_;
      4: return bus.dig_out_5_;
      5: return bus.dig_out_6_;
      6: return bus.dig_out_7_;
      7: return bus.dig_out_8_;
      8: return bus.dig_out_9_;
      default: return bus.dig_out_10_;
    endcase
  endfunction

  function automatic logic [63:0] model(input logic [63:0] d, input bit s, input int i);
    logic [63:0] mag;
    logic [63:0] r;
    bit          neg;
    neg = s && d[63];
    mag = neg ? -d : d;
    r   = mag % MODS[i];
    if (neg && r != 0) r = MODS[i] - r;
    return r;
  endfunction

  task automatic accept(input logic [63:0] d, input bit s);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_signed = s;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_data   = {$urandom, $urandom};
    bus.in_signed = ~s;
  endtask

  task automatic wait_done(input string tag);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
      end
      if (bus.out_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'd65);
  endtask

  task automatic check_digits(input string tag, input logic [63:0] d, input bit s);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_d%0d", tag, i + 1), 64'(dig(i)), model(d, s, i));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_idle_out_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] neg_one_exp [10];
    neg_one_exp = '{65535, 78124, 117648, 177146, 262026, 262048, 262050, 262068, 262078, 262102};
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_d1", 64'(bus.dig_out_1_), 64'd0);
    check("rst_d10", 64'(bus.dig_out_10_), 64'd0);
    rst_n = 1'b1;

    accept(64'd0, 1'b0);
    wait_done("zero");
    for (int i = 0; i < 10; i++) check($sformatf("zero_d%0d", i + 1), 64'(dig(i)), 64'd0);
    handshake("zero");

    accept(64'd1000000, 1'b0);
    wait_done("mil");
    check("mil_d1_const", 64'(bus.dig_out_1_), 64'd16960);
    check("mil_d2_const", 64'(bus.dig_out_2_), 64'd62500);
    check("mil_d3_const", 64'(bus.dig_out_3_), 64'd58808);
    check_digits("mil", 64'd1000000, 1'b0);
    handshake("mil");

    accept(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done("neg1");
    for (int i = 0; i < 10; i++) check($sformatf("neg1_d%0d", i + 1), 64'(dig(i)), neg_one_exp[i]);
    handshake("neg1");

    accept(64'h8000_0000_0000_0000, 1'b1);
    wait_done("minint");
    check("minint_d1_const", 64'(bus.dig_out_1_), 64'd0);
    check_digits("minint", 64'h8000_0000_0000_0000, 1'b1);
    handshake("minint");

    accept(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_done("umax");
    check_digits("umax", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    handshake("umax");

    accept(64'd262103, 1'b0);
    wait_done("bp");
    for (int c = 0; c < 10; c++) begin
      check("bp_d10_hold", 64'(bus.dig_out_10_), 64'd0);
      check("bp_d1_hold", 64'(bus.dig_out_1_), 64'd65495);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = 64'd999;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'd5;
    bus.in_signed = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_resume_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_resume_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 64'd12345;
    wait_done("five");
    check_digits("five", 64'd5, 1'b0);
    handshake("five");

    accept(64'hDEAD_BEEF_0123_4567, 1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_d2", 64'(bus.dig_out_2_), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);

    accept(64'd123456789, 1'b0);
    wait_done("post");
    check_digits("post", 64'd123456789, 1'b0);
    handshake("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
